// File: rtl/memory_map.sv
// Shared system memory map: RAM window, reset stack pointer and LED register address.
// The LED register is only decoded when DATA_BUS_LED_EN is defined.
package memory_map;

  localparam logic [63:0] MEM_BASE   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] MEM_END    = 64'h0000_0000_0000_03FF;
  localparam logic [63:0] INITIAL_SP = 64'h0000_0000_0000_03F0;
  localparam logic [63:0] LED_ADDR   = 64'h0000_0000_0000_1000;

  localparam int RAM_DEPTH = 1024;
  localparam int RAM_AW    = 10;

  function automatic logic [RAM_AW-1:0] ram_index(input logic [63:0] a);
    return a[RAM_AW-1:0];
  endfunction

endpackage

// File: rtl/data_bus_ram.sv
// 1024x64 synchronous single-port RAM: write enable, registered read port, no reset.
module data_bus_ram
  import memory_map::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [RAM_AW-1:0] i_idx,
  input  logic [63:0]       i_wdata,
  output logic [63:0]       o_rdata
);

  logic [63:0] r_mem [RAM_DEPTH];
  logic [63:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_bus.sv
// CPU data bus: address decode, RAM access, registered read data and access-fault flag.
// Define DATA_BUS_LED_EN to add the memory-mapped 8-bit LED register and led port.
module data_bus
  import memory_map::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rw,
  input  logic [63:0] addr,
  input  logic [63:0] write,
  output logic [63:0] read,
  output logic        exception
`ifdef DATA_BUS_LED_EN
  ,
  output logic [7:0]  led
`endif
);

  logic        w_ram_hit;
  logic        w_led_hit;
  logic        w_ram_we;
  logic [63:0] w_ram_q;

  logic        r_sel_ram;
  logic        r_sel_led;
  logic        r_exc;
  logic [7:0]  r_led;

  // Offset form keeps the range check correct for any MEM_BASE without a constant compare.
  assign w_ram_hit = (addr - MEM_BASE) <= (MEM_END - MEM_BASE);

`ifdef DATA_BUS_LED_EN
  assign w_led_hit = (addr == LED_ADDR);
`else
  assign w_led_hit = 1'b0;
`endif

  // Gating with rst_n drops a write that is pending while reset is held.
  assign w_ram_we = w_ram_hit & rw & rst_n;

  data_bus_ram u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_idx   (ram_index(addr)),
    .i_wdata (write),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_ram <= 1'b0;
      r_sel_led <= 1'b0;
      r_exc     <= 1'b0;
      r_led     <= 8'h00;
    end else begin
      r_sel_ram <= w_ram_hit & ~rw;
      r_sel_led <= w_led_hit & ~rw;
      r_exc     <= ~w_ram_hit & ~w_led_hit;
      if (w_led_hit && rw) r_led <= write[7:0];
    end
  end

  always_comb begin
    read = 64'h0;
    if (r_sel_ram)      read = w_ram_q;
    else if (r_sel_led) read = {56'h0, r_led};
  end

  assign exception = r_exc;

`ifdef DATA_BUS_LED_EN
  assign led = r_led;
`endif

endmodule

// File: tb/tb_data_bus.sv
// Randomized self-checking bench for data_bus against a word-level memory-map model.
// Builds with or without DATA_BUS_LED_EN.
module tb_data_bus;
  import memory_map::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rw;
  logic [63:0] addr;
  logic [63:0] write;
  logic [63:0] read;
  logic        exception;
`ifdef DATA_BUS_LED_EN
  logic [7:0]  led;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] m_mem   [RAM_DEPTH];
  bit          m_valid [RAM_DEPTH];
  logic [7:0]  m_led;

  always #5 clk = ~clk;

  data_bus dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rw        (rw),
    .addr      (addr),
    .write     (write),
    .read      (read),
    .exception (exception)
`ifdef DATA_BUS_LED_EN
    ,
    .led       (led)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one bus cycle, from the memory-map rules.
  task automatic model(input logic w, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] er, output logic ee, output bit known);
    er = 64'h0; ee = 1'b0; known = 1'b1;
    if (a >= MEM_BASE && a - MEM_BASE < 64'(RAM_DEPTH)) begin
      int idx = int'(a - MEM_BASE);
      if (w) begin
        m_mem[idx] = d; m_valid[idx] = 1'b1;
      end else begin
        er = m_mem[idx]; known = m_valid[idx];
      end
    end
`ifdef DATA_BUS_LED_EN
    else if (a == LED_ADDR) begin
      if (w) m_led = d[7:0];
      else   er = {56'h0, m_led};
    end
`endif
    else ee = 1'b1;
  endtask

  task automatic access(input string tag, input logic w, input logic [63:0] a,
                        input logic [63:0] d);
    logic [63:0] er; logic ee; bit known;
    rw = w; addr = a; write = d;
    @(posedge clk); #1;
    model(w, a, d, er, ee, known);
    if (known) check({tag, ".rd"}, read, er);
    check({tag, ".exc"}, {63'h0, exception}, {63'h0, ee});
`ifdef DATA_BUS_LED_EN
    check({tag, ".led"}, {56'h0, led}, {56'h0, m_led});
`endif
  endtask

  // Reset asserted mid-cycle with a write pending on the bus.
  task automatic do_reset(input string tag, input logic [63:0] a, input logic [63:0] d);
    rw = 1'b1; addr = a; write = d;
    #2 rst_n = 1'b0;
    #1;
    check({tag, ".rd_now"}, read, 64'h0);
    check({tag, ".exc_now"}, {63'h0, exception}, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".rd_hold"}, read, 64'h0);
    check({tag, ".exc_hold"}, {63'h0, exception}, 64'h0);
`ifdef DATA_BUS_LED_EN
    check({tag, ".led_hold"}, {56'h0, led}, 64'h0);
`endif
    m_led = 8'h00;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] k0, k5;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      m_mem[i] = 64'h0; m_valid[i] = 1'b0;
    end
    m_led = 8'h00;
    rst_n = 1'b0; rw = 1'b1; addr = 64'h0; write = 64'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rd", read, 64'h0);
    check("rst.exc", {63'h0, exception}, 64'h0);
`ifdef DATA_BUS_LED_EN
    check("rst.led", {56'h0, led}, 64'h0);
`endif
    rst_n = 1'b1;

    access("wr3f0", 1'b1, 64'h3F0, 64'hDEAD_BEEF_0123_4567);
    access("rd3f0", 1'b0, 64'h3F0, 64'h0);
    check("rd3f0.const", read, 64'hDEAD_BEEF_0123_4567);

    a = INITIAL_SP;
    while (a <= MEM_END) begin
      access("sweep_wr", 1'b1, a, a ^ 64'hA5A5);
      a++;
    end
    a = INITIAL_SP;
    while (a <= MEM_END) begin
      access("sweep_rd", 1'b0, a, 64'h0);
      check("sweep_rd.const", read, a ^ 64'hA5A5);
      a++;
    end

    // Reset must not write the pending bus data, and must clear outputs at once.
    k0 = {$urandom, $urandom};
    k5 = {$urandom, $urandom} | 64'h1;
    access("pre0", 1'b1, 64'h0, k0);
    access("pre5", 1'b1, 64'h5, k5);
    access("rd5", 1'b0, 64'h5, 64'h0);
    do_reset("mrst_rd", 64'h5, ~k5);
    access("fault", 1'b0, 64'h400, 64'h0);
    do_reset("mrst_exc", 64'h0, ~k0);
    access("post0", 1'b0, 64'h0, 64'h0);
    check("post0.const", read, k0);
    access("post5", 1'b0, 64'h5, 64'h0);
    check("post5.const", read, k5);

    access("bnd_end", 1'b0, MEM_END, 64'h0);
    check("bnd_end.const", read, MEM_END ^ 64'hA5A5);
    access("bnd_wrap", 1'b0, MEM_END + 64'h1, 64'h0);
    check("bnd_wrap.exc", {63'h0, exception}, 64'h1);
    access("bnd_clr", 1'b0, 64'h0, 64'h0);
    check("bnd_clr.exc", {63'h0, exception}, 64'h0);

    access("alias_wr", 1'b1, 64'h8000_0000_0000_03FF, 64'hFFFF);
    check("alias_wr.exc", {63'h0, exception}, 64'h1);
    access("alias_rd", 1'b0, 64'h3FF, 64'h0);
    check("alias_rd.const", read, 64'h3FF ^ 64'hA5A5);

    access("led_wr", 1'b1, LED_ADDR, 64'hB6);
`ifdef DATA_BUS_LED_EN
    check("led_wr.led", {56'h0, led}, 64'hB6);
    access("led_rd", 1'b0, LED_ADDR, 64'h0);
    check("led_rd.const", read, 64'hB6);
`else
    check("led_wr.exc", {63'h0, exception}, 64'h1);
`endif

    for (int n = 0; n < 1500; n++) begin
      logic w;
      w = 1'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    a = 64'($urandom_range(0, 63));
        2:       a = 64'($urandom_range(0, RAM_DEPTH - 1));
        3:       a = MEM_END - 64'd2 + 64'($urandom_range(0, 4));
        4:       a = LED_ADDR;
        default: a = {$urandom, $urandom};
      endcase
      access("rand", w, a, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
